// File: rtl/imu_trigger_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : imu_trigger_scheduler
//  Description : Schedules camera exposure triggers from the IMU data-ready
//                interrupt so every frame starts on a known IMU sample.
//                Provides a frame/trigger FSM, per-frame camera-busy gating,
//                frame-boundary reconfiguration of the frame length and a
//                watchdog that synthesises ticks when the IMU goes quiet.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk               in   system clock
//    rst_n             in   asynchronous active-low reset
//    imu_int           in   raw IMU interrupt (asynchronous, active-high)
//    enable            in   scheduler enable
//    samples_per_frame in   IMU ticks per frame (0 behaves as 1)
//    trigger_delay     in   cycles from frame tick to trigger assertion
//    trigger_width     in   trigger pulse length in cycles (0 behaves as 1)
//    cam_busy          in   per-camera readout-in-progress flags
//    cam_trigger       out  exposure trigger pulses (registered)
//    sample_count      out  IMU ticks since last frame tick
//    frame_count       out  frames triggered (wraps)
//    skipped_count     out  frames skipped (saturates)
//    imu_timeout       out  high while running on synthetic ticks
// ============================================================================
module imu_trigger_scheduler #(
    parameter int NUM_CAMS        = 3,
    parameter int TIMER_W         = 24,
    parameter int WATCHDOG_CYCLES = 400000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                imu_int,
    input  logic                enable,
    input  logic [7:0]          samples_per_frame,
    input  logic [TIMER_W-1:0]  trigger_delay,
    input  logic [TIMER_W-1:0]  trigger_width,
    input  logic [NUM_CAMS-1:0] cam_busy,
    output logic [NUM_CAMS-1:0] cam_trigger,
    output logic [7:0]          sample_count,
    output logic [15:0]         frame_count,
    output logic [15:0]         skipped_count,
    output logic                imu_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_PULSE = 2'd2
    } state_t;

    localparam logic [TIMER_W-1:0] WD_LAST = TIMER_W'(WATCHDOG_CYCLES - 1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic                r_sync1;
    logic                r_sync2;
    logic                r_sync3;
    logic [TIMER_W-1:0]  r_wd;
    logic                r_timeout;
    logic [7:0]          r_sample_cnt;
    logic [7:0]          r_spf_shadow;
    logic [15:0]         r_frame_cnt;
    logic [15:0]         r_skip_cnt;
    state_t              r_state;
    logic [TIMER_W-1:0]  r_timer;
    logic [NUM_CAMS-1:0] r_trig;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic               w_real_tick;
    logic               w_wd_hit;
    logic               w_tick;
    logic [7:0]         w_spf_eff;
    logic               w_frame_tick;
    logic               w_accept;
    logic               w_skip;
    logic [TIMER_W-1:0] w_width_m1;

    // Rising-edge detect on the synchronised interrupt: a long high time
    // still yields exactly one tick.
    assign w_real_tick  = r_sync2 & ~r_sync3;
    assign w_wd_hit     = (r_wd == WD_LAST);
    // A real tick coinciding with watchdog expiry merges into one tick.
    assign w_tick       = enable & (w_real_tick | w_wd_hit);
    assign w_spf_eff    = (samples_per_frame == 8'd0) ? 8'd1 : samples_per_frame;
    assign w_frame_tick = w_tick & (r_sample_cnt == (r_spf_shadow - 8'd1));
    assign w_accept     = w_frame_tick & (r_state == ST_IDLE) & ~(|cam_busy);
    assign w_skip       = w_frame_tick & ~w_accept;
    // Pulse timer counts down to zero, so it is loaded with width-1;
    // a zero width is stretched to one cycle.
    assign w_width_m1   = (trigger_width == '0) ? '0 : (trigger_width - 1'b1);

    // ------------------------------------------------------------------
    // Interrupt synchroniser plus history flop
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= imu_int;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    // ------------------------------------------------------------------
    // Watchdog and timeout flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd      <= '0;
            r_timeout <= 1'b0;
        end else if (!enable) begin
            r_wd      <= '0;
            r_timeout <= 1'b0;
        end else if (w_real_tick) begin
            // A real edge always wins and restarts the watchdog.
            r_wd      <= '0;
            r_timeout <= 1'b0;
        end else if (w_wd_hit) begin
            r_wd      <= '0;
            r_timeout <= 1'b1;
        end else begin
            r_wd      <= r_wd + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Sample counter and frame-length shadow. The shadow only reloads at
    // a frame boundary so a new frame length never truncates the frame
    // in progress.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sample_cnt <= 8'd0;
            r_spf_shadow <= 8'd1;
        end else if (!enable) begin
            r_sample_cnt <= 8'd0;
            r_spf_shadow <= w_spf_eff;
        end else if (w_frame_tick) begin
            r_sample_cnt <= 8'd0;
            r_spf_shadow <= w_spf_eff;
        end else if (w_tick) begin
            r_sample_cnt <= r_sample_cnt + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Frame and skip statistics
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= 16'd0;
            r_skip_cnt  <= 16'd0;
        end else begin
            if (w_accept) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            if (w_skip && (r_skip_cnt != 16'hFFFF)) begin
                r_skip_cnt <= r_skip_cnt + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Trigger FSM. Runs independently of enable so a delay or pulse in
    // flight always completes. Delay and width are captured when the
    // respective phase timer loads.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
            r_trig  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (trigger_delay == '0) begin
                            r_state <= ST_PULSE;
                            r_timer <= w_width_m1;
                            r_trig  <= {NUM_CAMS{1'b1}};
                        end else begin
                            r_state <= ST_DELAY;
                            r_timer <= trigger_delay - 1'b1;
                        end
                    end
                end
                ST_DELAY: begin
                    if (r_timer == '0) begin
                        r_state <= ST_PULSE;
                        r_timer <= w_width_m1;
                        r_trig  <= {NUM_CAMS{1'b1}};
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                ST_PULSE: begin
                    if (r_timer == '0) begin
                        r_state <= ST_IDLE;
                        r_trig  <= '0;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_timer <= '0;
                    r_trig  <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign cam_trigger   = r_trig;
    assign sample_count  = r_sample_cnt;
    assign frame_count   = r_frame_cnt;
    assign skipped_count = r_skip_cnt;
    assign imu_timeout   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_imu_trigger_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imu_trigger_scheduler
//  Description : Directed self-checking bench for imu_trigger_scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imu_trigger_scheduler;

    localparam int NUM_CAMS = 3;
    localparam int TIMER_W  = 24;
    localparam int WD_CYC   = 1000;

    logic                clk;
    logic                rst_n;
    logic                imu_int;
    logic                enable;
    logic [7:0]          samples_per_frame;
    logic [TIMER_W-1:0]  trigger_delay;
    logic [TIMER_W-1:0]  trigger_width;
    logic [NUM_CAMS-1:0] cam_busy;
    logic [NUM_CAMS-1:0] cam_trigger;
    logic [7:0]          sample_count;
    logic [15:0]         frame_count;
    logic [15:0]         skipped_count;
    logic                imu_timeout;

    int checks;
    int errors;
    int exp_frame;
    int exp_skip;

    imu_trigger_scheduler #(
        .NUM_CAMS        (NUM_CAMS),
        .TIMER_W         (TIMER_W),
        .WATCHDOG_CYCLES (WD_CYC)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .imu_int           (imu_int),
        .enable            (enable),
        .samples_per_frame (samples_per_frame),
        .trigger_delay     (trigger_delay),
        .trigger_width     (trigger_width),
        .cam_busy          (cam_busy),
        .cam_trigger       (cam_trigger),
        .sample_count      (sample_count),
        .frame_count       (frame_count),
        .skipped_count     (skipped_count),
        .imu_timeout       (imu_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Raise imu_int just after an edge (edge k is the next one), hold it for
    // 'hi' edges. With hi=3 the call returns 1 ns after edge k+2, when the
    // tick's effects on the counters and trigger are already visible.
    task automatic pulse_imu(input int hi);
        @(posedge clk); #1 imu_int = 1'b1;
        repeat (hi) @(posedge clk);
        #1 imu_int = 1'b0;
    endtask

    // Drop enable for one edge so the frame-length shadow reloads.
    task automatic reconfigure(input int spf, input int d, input int w);
        enable            = 1'b0;
        samples_per_frame = 8'(spf);
        trigger_delay     = TIMER_W'(d);
        trigger_width     = TIMER_W'(w);
        @(posedge clk); #1 enable = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; imu_int = 1'b0; enable = 1'b0; cam_busy = '0;
        samples_per_frame = 8'd1; trigger_delay = '0; trigger_width = 24'd1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        exp_frame = 0; exp_skip = 0;
        checks++; if (cam_trigger !== 3'b000) begin errors++; $display("FAIL reset_trig got %b exp 000", cam_trigger); end
        checks++; if (sample_count !== 8'd0) begin errors++; $display("FAIL reset_sample got %0d exp 0", sample_count); end
        checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL reset_frame got %0d exp 0", frame_count); end
        checks++; if (skipped_count !== 16'd0) begin errors++; $display("FAIL reset_skip got %0d exp 0", skipped_count); end
        checks++; if (imu_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b exp 0", imu_timeout); end
    endtask

    task automatic test_frame;
        int n;
        reconfigure(4, 0, 3);
        for (int i = 1; i <= 3; i++) begin
            pulse_imu(3);
            checks++; if (sample_count !== 8'(i)) begin errors++; $display("FAIL frame_sample%0d got %0d exp %0d", i, sample_count, i); end
            checks++; if (cam_trigger !== 3'b000) begin errors++; $display("FAIL frame_notrig%0d got %b exp 000", i, cam_trigger); end
        end
        pulse_imu(3);
        exp_frame++;
        checks++; if (sample_count !== 8'd0) begin errors++; $display("FAIL frame_wrap got %0d exp 0", sample_count); end
        checks++; if (frame_count !== 16'(exp_frame)) begin errors++; $display("FAIL frame_count got %0d exp %0d", frame_count, exp_frame); end
        checks++; if (cam_trigger !== 3'b111) begin errors++; $display("FAIL frame_trig got %b exp 111", cam_trigger); end
        n = 1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (cam_trigger === 3'b111) n++; else break;
        end
        checks++; if (n != 3) begin errors++; $display("FAIL frame_width got %0d exp 3", n); end
        // Long high time must still be a single tick.
        pulse_imu(12);
        checks++; if (sample_count !== 8'd1) begin errors++; $display("FAIL long_high got %0d exp 1", sample_count); end
    endtask

    task automatic test_delay;
        int c;
        int n;
        enable = 1'b0;
        pulse_imu(3);
        checks++; if (sample_count !== 8'd0) begin errors++; $display("FAIL disabled_sample got %0d exp 0", sample_count); end
        reconfigure(1, 5, 2);
        pulse_imu(3);
        exp_frame++;
        checks++; if (frame_count !== 16'(exp_frame)) begin errors++; $display("FAIL delay_frame got %0d exp %0d", frame_count, exp_frame); end
        checks++; if (cam_trigger !== 3'b000) begin errors++; $display("FAIL delay_early got %b exp 000", cam_trigger); end
        c = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1; c++;
            if (cam_trigger === 3'b111) break;
        end
        checks++; if (c != 5) begin errors++; $display("FAIL delay_len got %0d exp 5", c); end
        n = 1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (cam_trigger === 3'b111) n++; else break;
        end
        checks++; if (n != 2) begin errors++; $display("FAIL delay_width got %0d exp 2", n); end
    endtask

    task automatic test_reconfig;
        reconfigure(4, 0, 1);
        pulse_imu(3); pulse_imu(3);
        samples_per_frame = 8'd2;
        pulse_imu(3);
        checks++; if (sample_count !== 8'd3) begin errors++; $display("FAIL reconf_hold got %0d exp 3", sample_count); end
        pulse_imu(3);
        exp_frame++;
        checks++; if (sample_count !== 8'd0 || frame_count !== 16'(exp_frame)) begin errors++; $display("FAIL reconf_old got s%0d f%0d exp s0 f%0d", sample_count, frame_count, exp_frame); end
        pulse_imu(3);
        checks++; if (sample_count !== 8'd1) begin errors++; $display("FAIL reconf_new1 got %0d exp 1", sample_count); end
        pulse_imu(3);
        exp_frame++;
        checks++; if (sample_count !== 8'd0 || frame_count !== 16'(exp_frame)) begin errors++; $display("FAIL reconf_new got s%0d f%0d exp s0 f%0d", sample_count, frame_count, exp_frame); end
    endtask

    task automatic test_busy;
        reconfigure(1, 0, 1);
        cam_busy = 3'b010;
        pulse_imu(3);
        exp_skip++;
        checks++; if (skipped_count !== 16'(exp_skip)) begin errors++; $display("FAIL busy_skip got %0d exp %0d", skipped_count, exp_skip); end
        checks++; if (frame_count !== 16'(exp_frame)) begin errors++; $display("FAIL busy_frame got %0d exp %0d", frame_count, exp_frame); end
        checks++; if (cam_trigger !== 3'b000) begin errors++; $display("FAIL busy_trig got %b exp 000", cam_trigger); end
        cam_busy = 3'b000;
        pulse_imu(3);
        exp_frame++;
        checks++; if (frame_count !== 16'(exp_frame) || cam_trigger !== 3'b111) begin errors++; $display("FAIL busy_clear got f%0d t%b exp f%0d t111", frame_count, cam_trigger, exp_frame); end
    endtask

    task automatic test_overrun;
        reconfigure(1, 10, 10);
        repeat (3) @(posedge clk); #1;
        pulse_imu(3);
        exp_frame++;
        pulse_imu(3);
        exp_skip++;
        checks++; if (skipped_count !== 16'(exp_skip)) begin errors++; $display("FAIL overrun_skip got %0d exp %0d", skipped_count, exp_skip); end
        checks++; if (frame_count !== 16'(exp_frame)) begin errors++; $display("FAIL overrun_frame got %0d exp %0d", frame_count, exp_frame); end
        repeat (20) @(posedge clk); #1;
        pulse_imu(3);
        exp_frame++;
        checks++; if (frame_count !== 16'(exp_frame) || skipped_count !== 16'(exp_skip)) begin errors++; $display("FAIL overrun_recover got f%0d s%0d exp f%0d s%0d", frame_count, skipped_count, exp_frame, exp_skip); end
    endtask

    task automatic test_watchdog;
        int c;
        repeat (25) @(posedge clk); #1;
        reconfigure(1, 0, 1);
        c = 0;
        for (int i = 0; i < 1200; i++) begin
            @(posedge clk); #1; c++;
            if (imu_timeout === 1'b1) break;
        end
        exp_frame++;
        checks++; if (c != WD_CYC) begin errors++; $display("FAIL wd_first got %0d exp %0d", c, WD_CYC); end
        checks++; if (frame_count !== 16'(exp_frame) || cam_trigger !== 3'b111) begin errors++; $display("FAIL wd_trig got f%0d t%b exp f%0d t111", frame_count, cam_trigger, exp_frame); end
        repeat (999) @(posedge clk); #1;
        checks++; if (frame_count !== 16'(exp_frame)) begin errors++; $display("FAIL wd_early got %0d exp %0d", frame_count, exp_frame); end
        @(posedge clk); #1;
        exp_frame++;
        checks++; if (frame_count !== 16'(exp_frame) || imu_timeout !== 1'b1) begin errors++; $display("FAIL wd_second got f%0d to%b exp f%0d to1", frame_count, imu_timeout, exp_frame); end
        pulse_imu(3);
        exp_frame++;
        checks++; if (imu_timeout !== 1'b0 || frame_count !== 16'(exp_frame)) begin errors++; $display("FAIL wd_real got to%b f%0d exp to0 f%0d", imu_timeout, frame_count, exp_frame); end
    endtask

    task automatic test_reset_mid_pulse;
        reconfigure(2, 0, 20);
        pulse_imu(3); pulse_imu(3);
        checks++; if (cam_trigger !== 3'b111) begin errors++; $display("FAIL rstp_pre got %b exp 111", cam_trigger); end
        #2 rst_n = 1'b0;
        #1;
        exp_frame = 0; exp_skip = 0;
        checks++; if (cam_trigger !== 3'b000) begin errors++; $display("FAIL rstp_trig got %b exp 000", cam_trigger); end
        checks++; if (frame_count !== 16'd0 || skipped_count !== 16'd0 || sample_count !== 8'd0) begin errors++; $display("FAIL rstp_cnt got f%0d s%0d n%0d exp 0 0 0", frame_count, skipped_count, sample_count); end
        enable = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1 enable = 1'b1;
        pulse_imu(3);
        checks++; if (sample_count !== 8'd1 || cam_trigger !== 3'b000) begin errors++; $display("FAIL rstp_first got n%0d t%b exp n1 t000", sample_count, cam_trigger); end
        pulse_imu(3);
        exp_frame++;
        checks++; if (frame_count !== 16'(exp_frame) || cam_trigger !== 3'b111) begin errors++; $display("FAIL rstp_frame got f%0d t%b exp f%0d t111", frame_count, cam_trigger, exp_frame); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_frame();
        test_delay();
        test_reconfig();
        test_busy();
        test_overrun();
        test_watchdog();
        test_reset_mid_pulse();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
